// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder.
//   sadd_state_e : control FSM states
//                  IDLE : accepting operands
//                  RUN  : adding one chunk per clock
//                  DONE : holding the result until it is consumed
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports:
//   x, y  in  CHUNK  addend bits
//   ci    in  1      carry into bit 0
//   s     out CHUNK  sum bits
//   co    out 1      carry out of bit CHUNK-1
module adder_slice #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  // The ripple carry lives in a block-local variable so each bit's carry is
  // an intermediate value, not a flat self-referencing vector.
  always_comb begin : ripple
    logic cy;
    cy = ci;
    s  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds CHUNK bits of a WIDTH-bit addition per clock,
// carrying between chunks through a flop, with valid/ready handshakes.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands presented
//   in_ready   out  1      operands can be accepted (IDLE only)
//   a, b       in   WIDTH  operands, sampled on input handshake
//   cin        in   1      carry-in, sampled on input handshake
//   out_valid  out  1      result available (DONE only)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      unsigned carry-out
//   ovf        out  1      two's-complement overflow
//   busy       out  1      RUN or DONE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCH - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
      $error("serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  sadd_state_e state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [CHUNK-1:0]       slice_s;
  logic                   slice_co;
  logic [WIDTH+CHUNK-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_shift;
  logic                   accept;
  logic                   last_chunk;

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (a_sh[CHUNK-1:0]),
    .y  (b_sh[CHUNK-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New chunk enters at the MSB end; after NCH shifts the first chunk has
  // reached bit 0. Concatenate-then-slice also covers CHUNK == WIDTH.
  assign sum_cat    = {slice_s, sum_r};
  assign sum_shift  = sum_cat[WIDTH+CHUNK-1:CHUNK];
  assign accept     = in_valid && (state == IDLE);
  assign last_chunk = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry flop, counter, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= slice_co;
          sum_r <= sum_shift;
          cnt   <= cnt + CNT_W'(1);
          if (last_chunk) begin
            cout_r <= slice_co;
            // Overflow: like-signed operands producing an opposite-signed sum.
            ovf_r  <= (a_msb == b_msb) && (sum_shift[WIDTH-1] != a_msb);
          end
        end
        default: ;  // DONE: results frozen until consumed
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
